// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - Stereo I2S transmitter with frame timing and sample request strobe
//
// Serializes 16-bit two's complement left/right samples into a 64-bit-clock
// I2S frame (16 data bits + pad per channel, one-bit delay after each LRCK
// edge). Once per frame the sample pair is latched and next_sample pulses.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   left_audio   left sample, captured on the latch cycle only
//   right_audio  right sample, captured on the latch cycle only
//   mute         zeroes both captured words when high on the latch cycle
//   next_sample  one-clock request for the next sample pair
//   i2s_bck      serial bit clock
//   i2s_lrck     word select (0 = left, 1 = right)
//   i2s_data     serial data, MSB first

module audio_i2s_tx #(
   parameter int BCK_HALF = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] left_audio,
   input  logic [15:0] right_audio,
   input  logic        mute,
   output logic        next_sample,
   output logic        i2s_bck,
   output logic        i2s_lrck,
   output logic        i2s_data
);

   localparam logic [7:0] DIV_LAST = 8'(BCK_HALF - 1);

   logic [7:0]  div_cnt;
   logic [5:0]  slot;
   logic [15:0] left_hold;
   logic [15:0] right_hold;

   logic        div_last;
   logic        bck_fall;
   logic        wrap;
   logic [5:0]  slot_nxt;
   logic [3:0]  bit_idx;
   logic        data_nxt;

   // The bit sent in slot k = slot+1 is bit (16-k) of left or (48-k) of
   // right; both reduce to bit (15 - slot[3:0]) while slot is in 0..15 or
   // 32..47. slot[4] set means the next slot is pad (or the delay bit).
   always_comb begin
      div_last = (div_cnt == DIV_LAST);
      bck_fall = div_last && i2s_bck;
      wrap     = bck_fall && (slot == 6'd63);
      slot_nxt = slot + 6'd1;
      bit_idx  = ~slot[3:0];
      data_nxt = 1'b0;
      if (!slot[4]) begin
         data_nxt = slot[5] ? right_hold[bit_idx] : left_hold[bit_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt     <= 8'd0;
         slot        <= 6'd63;
         left_hold   <= 16'd0;
         right_hold  <= 16'd0;
         next_sample <= 1'b0;
         i2s_bck     <= 1'b0;
         i2s_lrck    <= 1'b0;
         i2s_data    <= 1'b0;
      end else begin
         next_sample <= wrap;
         if (div_last) begin
            div_cnt <= 8'd0;
            i2s_bck <= ~i2s_bck;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
         // Serial outputs move only with the falling bit clock, so they are
         // stable at every rising edge seen by the DAC.
         if (bck_fall) begin
            slot     <= slot_nxt;
            i2s_lrck <= slot_nxt[5];
            i2s_data <= data_nxt;
         end
         if (wrap) begin
            left_hold  <= mute ? 16'd0 : left_audio;
            right_hold <= mute ? 16'd0 : right_audio;
         end
      end
   end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Stereo I2S transmitter that serializes the 16-bit signed left/right mix from the PSG to an external audio DAC. It owns the audio frame timing: it generates bit clock, word select and serial data from the system clock. Once per frame it latches a new sample pair and issues a one-cycle `next_sample` strobe that starts the PSG's channel sweep. Each sample reaches the DAC one frame after it is latched.

## Interface
- `BCK_HALF`, default 4: system clocks per half bit-clock period; legal values are 1 to 255.
- `clk` in 1: system clock; every register is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `left_audio` in 16: signed left sample; sampled only on the latch cycle.
- `right_audio` in 16: signed right sample; sampled only on the latch cycle.
- `mute` in 1: when high on the latch cycle, both latched words become 0.
- `next_sample` out 1: one-clock pulse, once per frame; request for the next sample pair.
- `i2s_bck` out 1: serial bit clock.
- `i2s_lrck` out 1: word select; 0 = left, 1 = right.
- `i2s_data` out 1: serial data, MSB first.

## Operation
- **Divider.** `div_cnt` counts 0 to `BCK_HALF`-1. At terminal count it wraps to 0 and `i2s_bck` toggles.
- **bck_fall.** Defined as terminal count while `i2s_bck`=1. All serial state advances only on bck_fall.
- **Slot counter.** `slot` is 6 bits, counts 0 to 63 and wraps; one frame is 64 bit clocks.
- **Word select.** On bck_fall into slot k, `i2s_lrck` becomes (k ≥ 32).
- **Data.** On bck_fall into slot k, `i2s_data` is set as follows:
  - k in 1..16: bit (16-k) of the left hold register, so k=1 carries the MSB.
  - k in 33..48: bit (48-k) of the right hold register.
  - All other slots: 0. This gives the standard I2S one-bit delay after each LRCK edge, with the 16-bit word followed by 15 zero pad bits.
- **Latch.**
  - The latch cycle is the bck_fall that wraps `slot` from 63 to 0.
  - On that cycle, `left_audio`/`right_audio` are copied into the 16-bit hold registers, or 0 if `mute`=1.
  - Inputs are ignored on every other cycle.
- **Strobe.** `next_sample` is registered: it is high for exactly the one clock after the latch cycle, otherwise 0. This leaves the PSG a full frame to produce the next pair.
- **Data format.** Samples pass unmodified as two's complement. There is no rounding, saturation or width change.
- **Reset state.**
  - `div_cnt`=0, `slot`=63, both hold registers 0.
  - Outputs: `i2s_bck`=0, `i2s_lrck`=0, `i2s_data`=0, `next_sample`=0.
  - The first bck_fall after release is therefore a latch cycle.
- **Reset mid-frame.** Assertion clears everything immediately, without waiting for `clk`. The partial frame is abandoned and there is no glitch pulse on `next_sample`. After release the block restarts cleanly at the reset state.
- **Simultaneous events.**
  - An input change in the latch cycle itself is captured as presented at that clock edge.
  - `mute` changes take effect at the next frame boundary only.

## Timing
- Bit clock frequency is f_clk/(2·`BCK_HALF`); frame length is 128·`BCK_HALF` clocks. At 25 MHz with `BCK_HALF`=4 this is 48.83 kHz.
- After reset release, `i2s_bck` first rises at the end of clock `BCK_HALF` and first falls at the end of clock 2·`BCK_HALF`. The first latch happens on that fall.
- `i2s_lrck` and `i2s_data` change only in the same clock that `i2s_bck` falls, so they are stable across every rising bck edge.
- `next_sample` occurs 1 clock after each latch; pulse spacing is exactly 128·`BCK_HALF` clocks.
- Latency from input to DAC:
  - Left MSB appears on `i2s_data` 2·`BCK_HALF` clocks after the latch (slot 1).
  - Right MSB appears 66·`BCK_HALF` clocks after the latch (slot 33).
- With `BCK_HALF`=1, `i2s_bck` toggles every clock and the frame is 128 clocks. Edge alignment is unchanged.

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-operation → all four outputs are 0 immediately. Release → `i2s_bck` rises after 4 clocks and falls after 8 (`BCK_HALF`=4), and `next_sample` pulses on the 9th clock.
- **Serialization.** Hold left=16'hA5C3, right=16'h0F0F. Deserialize the second frame on rising bck → left slots 1..16 read A5C3 and right slots 33..48 read 0F0F. Slots 0, 17..31, 32 and 49..63 read 0. `i2s_lrck` is 0 for slots 0..31 and 1 for slots 32..63.
- **Strobe spacing.** Run 10 frames with `BCK_HALF`=4 → `next_sample` is exactly one clock wide, 512 clocks apart, and always 1 clock after a 63→0 wrap.
- **Mid-frame input change.** Change inputs to 16'h8000/16'h7FFF at slot 20 → the current frame is unaffected; the next frame carries 8000/7FFF. Check sign bit 1/0 as the MSB of each word.
- **Mute.** Set `mute`=1 before a latch with left=16'hFFFF → the following frame's data is all 0. Deassert `mute` → the next frame restores FFFF.
- **Minimum divider.** Set `BCK_HALF`=1 with left=16'h0001, right=16'h8000 → `i2s_bck` toggles every clock and the frame is 128 clocks. The left LSB is at slot 16 and the right MSB at slot 33.
